// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: load-type codes, writeback entry state
// encoding and the hard-wired zero register index.
package mips_pkg;

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    localparam logic [1:0] WB_EMPTY   = 2'd0;
    localparam logic [1:0] WB_PENDING = 2'd1;
    localparam logic [1:0] WB_DONE    = 2'd2;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM/WB bus: MEM-stage fields and pipeline control in, register-file write
// triple, decode bypass and retirement count out.
interface writeback_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              mem_valid;
    logic              mem_reg_write;
    logic              mem_mem_to_reg;
    logic [2:0]        mem_load_type;
    logic [1:0]        mem_byte_off;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_read_data;
    logic [REG_AW-1:0] mem_dest;
    logic              stall;
    logic              flush;
    logic [REG_AW-1:0] read_register1;
    logic [REG_AW-1:0] read_register2;
    logic [REG_AW-1:0] write_register;
    logic [DATA_W-1:0] in_data;
    logic              write_enable;
    logic              bypass_hit1;
    logic              bypass_hit2;
    logic [DATA_W-1:0] bypass_data1;
    logic [DATA_W-1:0] bypass_data2;
    logic [CNT_W-1:0]  retired_count;

    modport master (
        output mem_valid, mem_reg_write, mem_mem_to_reg, mem_load_type,
               mem_byte_off, mem_alu_result, mem_read_data, mem_dest,
               stall, flush, read_register1, read_register2,
        input  write_register, in_data, write_enable,
               bypass_hit1, bypass_hit2, bypass_data1, bypass_data2,
               retired_count
    );

    modport slave (
        input  mem_valid, mem_reg_write, mem_mem_to_reg, mem_load_type,
               mem_byte_off, mem_alu_result, mem_read_data, mem_dest,
               stall, flush, read_register1, read_register2,
        output write_register, in_data, write_enable,
               bypass_hit1, bypass_hit2, bypass_data1, bypass_data2,
               retired_count
    );
endinterface

// File: rtl/writeback_stage_load_extend.sv
// Big-endian load byte/half extraction with sign or zero extension
// (purely combinational, 32-bit words).
module load_extend
    import mips_pkg::*;
(
    input  logic [31:0] read_data,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  load_type,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte k is the k-th most significant byte of the word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = read_data[31-8*gi -: 8];
        end
    endgenerate

    always_comb begin
        byte_sel = byte_lane[byte_off];
        half_sel = byte_off[1] ? read_data[15:0] : read_data[31:16];
        case (load_type)
            LT_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  load_data = {24'd0, byte_sel};
            LT_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  load_data = {16'd0, half_sel};
            default: load_data = read_data;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and register-file write generation.
// Optional decode-stage forwarding of the pending write: define WB_BYPASS_EN.
module writeback_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input logic               clk,
    input logic               rst_n,
    writeback_stage_if.slave  wb
);

    logic [1:0]        state_reg, state_next;
    logic              reg_write_reg;
    logic              mem_to_reg_reg;
    logic [2:0]        load_type_reg;
    logic [1:0]        byte_off_reg;
    logic [DATA_W-1:0] alu_reg;
    logic [DATA_W-1:0] read_data_reg;
    logic [REG_AW-1:0] dest_reg;
    logic [CNT_W-1:0]  retired_reg;
    logic [DATA_W-1:0] load_word;
    logic              write_hit;

    // Flush wins over stall; a stalled entry that has been written parks in DONE.
    always_comb begin
        if (wb.flush)
            state_next = WB_EMPTY;
        else if (wb.stall)
            state_next = (state_reg == WB_EMPTY) ? WB_EMPTY : WB_DONE;
        else
            state_next = wb.mem_valid ? WB_PENDING : WB_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= WB_EMPTY;
            reg_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            load_type_reg  <= LT_LW;
            byte_off_reg   <= 2'd0;
            alu_reg        <= '0;
            read_data_reg  <= '0;
            dest_reg       <= '0;
            retired_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (!wb.stall) begin
                reg_write_reg  <= wb.mem_reg_write;
                mem_to_reg_reg <= wb.mem_mem_to_reg;
                load_type_reg  <= wb.mem_load_type;
                byte_off_reg   <= wb.mem_byte_off;
                alu_reg        <= wb.mem_alu_result;
                read_data_reg  <= wb.mem_read_data;
                dest_reg       <= wb.mem_dest;
            end
            // Any edge seen in PENDING is the edge at which that write lands.
            if (state_reg == WB_PENDING)
                retired_reg <= retired_reg + CNT_W'(1);
        end
    end

    generate
        if (DATA_W == 32) begin : g_ext
            load_extend u_load_extend (
                .read_data (read_data_reg),
                .byte_off  (byte_off_reg),
                .load_type (load_type_reg),
                .load_data (load_word)
            );
        end else begin : g_raw
            assign load_word = read_data_reg;
        end
    endgenerate

    assign write_hit = (state_reg == WB_PENDING) && reg_write_reg &&
                       (dest_reg != REG_AW'(REG_ZERO));

    assign wb.write_enable   = write_hit;
    assign wb.write_register = dest_reg;
    assign wb.in_data        = mem_to_reg_reg ? load_word : alu_reg;
    assign wb.retired_count  = retired_reg;

`ifdef WB_BYPASS_EN
    logic [REG_AW-1:0] rd_addr [2];
    logic              hit     [2];

    assign rd_addr[0] = wb.read_register1;
    assign rd_addr[1] = wb.read_register2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_byp
            assign hit[gi] = write_hit && (dest_reg == rd_addr[gi]);
        end
    endgenerate

    assign wb.bypass_hit1  = hit[0];
    assign wb.bypass_hit2  = hit[1];
    assign wb.bypass_data1 = wb.in_data;
    assign wb.bypass_data2 = wb.in_data;
`else
    logic unused_rd_addr;
    assign unused_rd_addr  = ^{wb.read_register1, wb.read_register2};
    assign wb.bypass_hit1  = 1'b0;
    assign wb.bypass_hit2  = 1'b0;
    assign wb.bypass_data1 = '0;
    assign wb.bypass_data2 = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed table-driven bench for writeback_stage with a small register-file
// model; expectations follow WB_BYPASS_EN when it is defined.
module tb_writeback_stage;
    import mips_pkg::*;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    writeback_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) wb ();

    writeback_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rf [32];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (wb.write_enable) begin
            rf[wb.write_register] <= wb.in_data;
        end
    end

    typedef struct {
        logic        valid;
        logic        rw;
        logic        m2r;
        logic        flush;
        logic [2:0]  lt;
        logic [1:0]  off;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [4:0]  dest;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(logic valid, logic rw, logic m2r, logic flush,
                                logic [2:0] lt, logic [1:0] off, logic [31:0] alu,
                                logic [4:0] dest, logic exp_we, logic [31:0] exp_data);
        vec_t v;
        v.valid = valid; v.rw = rw; v.m2r = m2r; v.flush = flush;
        v.lt = lt; v.off = off; v.alu = alu; v.rd = 32'h80FF_7F01;
        v.dest = dest; v.exp_we = exp_we; v.exp_data = exp_data;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic rw, input logic m2r,
                         input logic [2:0] lt, input logic [1:0] off,
                         input logic [31:0] alu, input logic [31:0] rd,
                         input logic [4:0] dest, input logic stall, input logic flush);
        wb.mem_valid      = valid;
        wb.mem_reg_write  = rw;
        wb.mem_mem_to_reg = m2r;
        wb.mem_load_type  = lt;
        wb.mem_byte_off   = off;
        wb.mem_alu_result = alu;
        wb.mem_read_data  = rd;
        wb.mem_dest       = dest;
        wb.stall          = stall;
        wb.flush          = flush;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int we_cycles;
        tests  = 0;
        failed = 0;
        rst_n  = 1'b0;
        drive(0, 0, 0, LT_LW, 0, 0, 0, 0, 0, 0);
        wb.read_register1 = 5'd0;
        wb.read_register2 = 5'd0;

        vecs[0]  = mk(1, 1, 0, 0, LT_LW,  2'd0, 32'h0000_0064, 5'd30, 1, 32'h0000_0064);
        vecs[1]  = mk(1, 1, 1, 0, LT_LB,  2'd0, 32'h0000_DEAD, 5'd5,  1, 32'hFFFF_FF80);
        vecs[2]  = mk(1, 1, 1, 0, LT_LBU, 2'd1, 32'h0000_DEAD, 5'd6,  1, 32'h0000_00FF);
        vecs[3]  = mk(1, 1, 1, 0, LT_LH,  2'd2, 32'h0000_DEAD, 5'd7,  1, 32'h0000_7F01);
        vecs[4]  = mk(1, 1, 1, 0, LT_LHU, 2'd0, 32'h0000_DEAD, 5'd8,  1, 32'h0000_80FF);
        vecs[5]  = mk(1, 1, 1, 0, LT_LW,  2'd3, 32'h0000_DEAD, 5'd9,  1, 32'h80FF_7F01);
        vecs[6]  = mk(1, 1, 1, 0, LT_LB,  2'd3, 32'h0000_DEAD, 5'd10, 1, 32'h0000_0001);
        vecs[7]  = mk(1, 1, 1, 0, LT_LH,  2'd3, 32'h0000_DEAD, 5'd11, 1, 32'h0000_7F01);
        vecs[8]  = mk(1, 1, 1, 0, LT_LB,  2'd2, 32'h0000_DEAD, 5'd12, 1, 32'h0000_007F);
        vecs[9]  = mk(1, 1, 1, 0, 3'b111, 2'd1, 32'h0000_DEAD, 5'd13, 1, 32'h80FF_7F01);
        vecs[10] = mk(1, 1, 0, 0, LT_LW,  2'd0, 32'h0000_000A, 5'd0,  0, 32'h0000_000A);
        vecs[11] = mk(1, 0, 0, 0, LT_LW,  2'd0, 32'h0000_0005, 5'd14, 0, 32'h0000_0005);
        vecs[12] = mk(0, 1, 0, 0, LT_LW,  2'd0, 32'h0000_0007, 5'd15, 0, 32'h0000_0007);
        vecs[13] = mk(1, 1, 0, 1, LT_LW,  2'd0, 32'h0000_0009, 5'd16, 0, 32'h0000_0009);

        #1;
        check("reset_we",      {31'd0, wb.write_enable}, 32'd0);
        check("reset_wreg",    {27'd0, wb.write_register}, 32'd0);
        check("reset_data",    wb.in_data, 32'd0);
        check("reset_retired", wb.retired_count, 32'd0);
        check("reset_hits",    {30'd0, wb.bypass_hit1, wb.bypass_hit2}, 32'd0);
        check("reset_bdata",   wb.bypass_data1 | wb.bypass_data2, 32'd0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].rw, vecs[i].m2r, vecs[i].lt, vecs[i].off,
                  vecs[i].alu, vecs[i].rd, vecs[i].dest, 1'b0, vecs[i].flush);
            wb.read_register1 = vecs[i].dest;
            wb.read_register2 = 5'd31;
            @(posedge clk);
            #1;
            $display("[TB] vec %0d dest=%0d we=%0b data=0x%08h", i, wb.write_register,
                     wb.write_enable, wb.in_data);
            check($sformatf("vec%0d_we", i), {31'd0, wb.write_enable}, {31'd0, vecs[i].exp_we});
            check($sformatf("vec%0d_wreg", i), {27'd0, wb.write_register}, {27'd0, vecs[i].dest});
            check($sformatf("vec%0d_data", i), wb.in_data, vecs[i].exp_data);
            check($sformatf("vec%0d_hit1", i), {31'd0, wb.bypass_hit1},
                  {31'd0, BYP & vecs[i].exp_we});
        end
        check("table_retired", wb.retired_count, 32'd12);
        check("rf_r30", rf[30], 32'd100);
        check("rf_r5",  rf[5],  32'hFFFF_FF80);
        check("rf_r0",  rf[0],  32'd0);

        // Stall: one write across three held cycles.
        @(negedge clk);
        drive(1, 1, 0, LT_LW, 0, 32'd90, 0, 5'd8, 0, 0);
        @(posedge clk);
        #1;
        we_cycles = int'(wb.write_enable);
        $display("[TB] stall capture dest=%0d we=%0b", wb.write_register, wb.write_enable);
        @(negedge clk);
        drive(0, 1, 0, LT_LW, 0, 32'd0, 0, 5'd3, 1, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            we_cycles += int'(wb.write_enable);
            $display("[TB] stall cycle %0d we=%0b dest=%0d", c, wb.write_enable, wb.write_register);
            check($sformatf("stall%0d_wreg", c), {27'd0, wb.write_register}, 32'd8);
        end
        @(negedge clk);
        wb.stall = 1'b0;
        @(posedge clk);
        #1;
        we_cycles += int'(wb.write_enable);
        check("stall_we_cycles", we_cycles, 32'd1);
        check("stall_retired", wb.retired_count, 32'd13);
        check("stall_rf_r8", rf[8], 32'd90);

        // Flush with stall at the capture edge from EMPTY.
        @(negedge clk);
        drive(1, 1, 0, LT_LW, 0, 32'h77, 0, 5'd20, 1, 1);
        @(posedge clk);
        #1;
        $display("[TB] flush+stall empty we=%0b", wb.write_enable);
        check("flush_empty_we", {31'd0, wb.write_enable}, 32'd0);
        check("flush_empty_retired", wb.retired_count, 32'd13);

        // Flush with stall while an entry is pending: it still writes once.
        @(negedge clk);
        drive(1, 1, 0, LT_LW, 0, 32'h21, 0, 5'd21, 0, 0);
        @(posedge clk);
        #1;
        check("flush_pend_we", {31'd0, wb.write_enable}, 32'd1);
        @(negedge clk);
        drive(1, 1, 0, LT_LW, 0, 32'h22, 0, 5'd22, 1, 1);
        @(posedge clk);
        #1;
        $display("[TB] flush+stall pending we=%0b retired=%0d", wb.write_enable, wb.retired_count);
        check("flush_pend_we_after", {31'd0, wb.write_enable}, 32'd0);
        check("flush_pend_retired", wb.retired_count, 32'd14);
        check("flush_pend_rf_r21", rf[21], 32'h21);

        // Bypass of a pending write.
        @(negedge clk);
        drive(1, 1, 0, LT_LW, 0, 32'h1234, 0, 5'd9, 0, 0);
        wb.read_register1 = 5'd9;
        wb.read_register2 = 5'd0;
        @(posedge clk);
        #1;
        $display("[TB] bypass hit1=%0b hit2=%0b data1=0x%08h", wb.bypass_hit1,
                 wb.bypass_hit2, wb.bypass_data1);
        check("byp_hit1",  {31'd0, wb.bypass_hit1}, {31'd0, BYP});
        check("byp_data1", wb.bypass_data1, BYP ? 32'h1234 : 32'd0);
        check("byp_hit2",  {31'd0, wb.bypass_hit2}, 32'd0);
        check("byp_we",    {31'd0, wb.write_enable}, 32'd1);

        // Asynchronous reset while the entry is pending.
        #3;
        rst_n = 1'b0;
        #1;
        $display("[TB] mid-pending reset we=%0b data=0x%08h", wb.write_enable, wb.in_data);
        check("rst_we",      {31'd0, wb.write_enable}, 32'd0);
        check("rst_wreg",    {27'd0, wb.write_register}, 32'd0);
        check("rst_data",    wb.in_data, 32'd0);
        check("rst_hit1",    {31'd0, wb.bypass_hit1}, 32'd0);
        check("rst_retired", wb.retired_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
